// File: rtl/bram_rd_scheduler.sv
// Two-requester burst read scheduler driving a single-port BRAM read port.
// Latency: grant in cycle N, address cycles N+1..N+len, data at address cycle + RD_LAT + 1.
// Backpressure: req_ready is a one-cycle accept pulse; there is none on the read-data side.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ram_clk/rst/en/addr/we/wd_data, ram_rd_data   BRAM port (read-only use)
//   req_valid[1:0], req_addr0/1, req_len0/1, req_ready[1:0]   burst request side
//   rd_valid, rd_data, rd_id, rd_last             read-data stream, in issue order
//   busy                                          grant, issuing or reads in flight
module bram_rd_scheduler #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ram_clk,
   output logic              ram_rst,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_we,
   output logic [DATA_W-1:0] ram_wd_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   input  logic [1:0]        req_valid,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [LEN_W-1:0]  req_len0,
   input  logic [LEN_W-1:0]  req_len1,
   output logic [1:0]        req_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_id,
   output logic              rd_last,
   output logic              busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]        state;
   logic              rr_prio;     // requester that wins a tie
   logic              cur_id;      // requester owning the burst being issued
   logic [LEN_W-1:0]  cnt;         // address cycles remaining after the current one
   logic              gnt_any;
   logic              gnt_id;
   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_id;
   logic [RD_LAT-1:0] pipe_last;

   assign ram_clk     = clk;
   assign ram_rst     = 1'b0;
   assign ram_we      = 4'b0000;
   assign ram_wd_data = '0;

   // Requests are only looked at in IDLE; a tie goes to rr_prio.
   always_comb begin
      gnt_any = (state == S_IDLE) && (req_valid != 2'b00);
      gnt_id  = 1'b0;
      case (req_valid)
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = rr_prio;
         default: gnt_id = 1'b0;
      endcase
   end

   // The accept pulse is combinational with the grant, so it is gated by
   // rst_n to stay low while reset is held with requests pending.
   assign req_ready = (gnt_any && rst_n) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

   assign busy = rst_n && (gnt_any || (state == S_ISSUE) || (pipe_vld != '0) || rd_valid);

   // Address generator. Loading len-1 into cnt makes len=0 naturally
   // produce 2^LEN_W address cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ram_en   <= 1'b0;
         ram_addr <= '0;
         cnt      <= '0;
         cur_id   <= 1'b0;
         rr_prio  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  state    <= S_ISSUE;
                  ram_en   <= 1'b1;
                  ram_addr <= gnt_id ? req_addr1 : req_addr0;
                  cnt      <= (gnt_id ? req_len1 : req_len0) - LEN_W'(1);
                  cur_id   <= gnt_id;
                  rr_prio  <= ~gnt_id;
               end else begin
                  ram_en   <= 1'b0;
               end
            end
            default: begin
               if (cnt == '0) begin
                  state  <= S_IDLE;
                  ram_en <= 1'b0;
               end else begin
                  ram_en   <= 1'b1;
                  ram_addr <= ram_addr + ADDR_W'(4);
                  cnt      <= cnt - LEN_W'(1);
               end
            end
         endcase
      end
   end

   // Tag pipeline: stage RD_LAT-1 lines up with ram_rd_data for its address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld  <= '0;
         pipe_id   <= '0;
         pipe_last <= '0;
      end else begin
         pipe_vld[0]  <= ram_en;
         pipe_id[0]   <= ram_en & cur_id;
         pipe_last[0] <= ram_en & (cnt == '0);
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_id[i]   <= pipe_id[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
      end
   end

   // Output register; rd_data keeps its last word between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_id    <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         rd_valid <= pipe_vld[RD_LAT-1];
         rd_id    <= pipe_vld[RD_LAT-1] & pipe_id[RD_LAT-1];
         rd_last  <= pipe_vld[RD_LAT-1] & pipe_last[RD_LAT-1];
         if (pipe_vld[RD_LAT-1]) begin
            rd_data <= ram_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_bram_rd_scheduler.sv
// Testbench for bram_rd_scheduler: RD_LAT=1 and RD_LAT=3 instances on shared inputs.
// Latency: directed per-cycle vectors plus event logs checked against cycle offsets.
// Backpressure: requesters drop req_valid after an accept unless the test holds them.
module tb_bram_rd_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  req_valid;
   logic [31:0] req_addr0, req_addr1;
   logic [7:0]  req_len0, req_len1;

   logic        u1_rclk, u1_rrst, u1_en, u1_rv, u1_id, u1_last, u1_busy;
   logic [31:0] u1_addr, u1_wd, u1_rdin, u1_rd;
   logic [3:0]  u1_we;
   logic [1:0]  u1_rdy;
   logic        u3_rclk, u3_rrst, u3_en, u3_rv, u3_id, u3_last, u3_busy;
   logic [31:0] u3_addr, u3_wd, u3_rdin, u3_rd;
   logic [3:0]  u3_we;
   logic [1:0]  u3_rdy;

   bram_rd_scheduler #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .RD_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .ram_clk(u1_rclk), .ram_rst(u1_rrst), .ram_en(u1_en),
      .ram_addr(u1_addr), .ram_we(u1_we), .ram_wd_data(u1_wd), .ram_rd_data(u1_rdin),
      .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_len0(req_len0), .req_len1(req_len1), .req_ready(u1_rdy),
      .rd_valid(u1_rv), .rd_data(u1_rd), .rd_id(u1_id), .rd_last(u1_last), .busy(u1_busy));

   bram_rd_scheduler #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .RD_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .ram_clk(u3_rclk), .ram_rst(u3_rrst), .ram_en(u3_en),
      .ram_addr(u3_addr), .ram_we(u3_we), .ram_wd_data(u3_wd), .ram_rd_data(u3_rdin),
      .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_len0(req_len0), .req_len1(req_len1), .req_ready(u3_rdy),
      .rd_valid(u3_rv), .rd_data(u3_rd), .rd_id(u3_id), .rd_last(u3_last), .busy(u3_busy));

   // BRAM contents are a fixed scramble of the address.
   function automatic logic [31:0] fmem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   logic [31:0] m1;
   logic [31:0] m3 [3];
   always @(posedge clk) begin
      m1    <= u1_en ? fmem(u1_addr) : 32'hDEAD_BEEF;
      m3[0] <= u3_en ? fmem(u3_addr) : 32'hDEAD_BEEF;
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign u1_rdin = m1;
   assign u3_rdin = m3[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] v;
      logic        id;
      logic        last;
   } ev_t;

   function automatic ev_t mkev(input int c, input logic [31:0] v, input logic id, input logic last);
      ev_t e;
      e.cyc = c; e.v = v; e.id = id; e.last = last;
      return e;
   endfunction

   ev_t g1_q[$], a1_q[$], r1_q[$], a3_q[$], r3_q[$];

   always @(negedge clk) begin
      if (u1_rdy != 2'b00) g1_q.push_back(mkev(cyc, 32'h0, u1_rdy[1], 1'b0));
      if (u1_en)           a1_q.push_back(mkev(cyc, u1_addr, 1'b0, 1'b0));
      if (u1_rv)           r1_q.push_back(mkev(cyc, u1_rd, u1_id, u1_last));
      if (u3_en)           a3_q.push_back(mkev(cyc, u3_addr, 1'b0, 1'b0));
      if (u3_rv)           r3_q.push_back(mkev(cyc, u3_rd, u3_id, u3_last));
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  vld;
      logic [31:0] a0;
      logic [7:0]  l0;
      logic [31:0] a1;
      logic [7:0]  l1;
      logic [70:0] exp;   // {rdy, en, addr, rv, data, id, last, busy}
   } vec_t;

   function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, input logic [7:0] l0,
                               input logic [31:0] a1, input logic [7:0] l1, input logic [1:0] rdy,
                               input logic en, input logic [31:0] ad, input logic rv,
                               input logic [31:0] dat, input logic id, input logic last,
                               input logic bsy);
      vec_t t;
      t.vld = vld; t.a0 = a0; t.l0 = l0; t.a1 = a1; t.l1 = l1;
      t.exp = {rdy, en, ad, rv, dat, id, last, bsy};
      return t;
   endfunction

   function automatic logic [70:0] u1_outs();
      return {u1_rdy, u1_en, u1_addr, u1_rv, u1_rd, u1_id, u1_last, u1_busy};
   endfunction

   function automatic logic [70:0] u3_outs();
      return {u3_rdy, u3_en, u3_addr, u3_rv, u3_rd, u3_id, u3_last, u3_busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      req_valid = 2'b00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   localparam logic [31:0] A = 32'h4580_0000;
   localparam logic [31:0] B = 32'h0000_0100;

   vec_t vt[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_g, b_a, b_r, g0, bad, nlast;
      logic [1:0] acc;

      vt[0]  = mk(2'b01, A, 8'd4, B, 8'd1, 2'b01, 1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
      vt[1]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b1, A,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
      vt[2]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b1, A+4,    1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
      vt[3]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b1, A+8,    1'b1, fmem(A),      1'b0, 1'b0, 1'b1);
      vt[4]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b1, A+12,   1'b1, fmem(A+4),    1'b0, 1'b0, 1'b1);
      vt[5]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, A+12,   1'b1, fmem(A+8),    1'b0, 1'b0, 1'b1);
      vt[6]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, A+12,   1'b1, fmem(A+12),   1'b0, 1'b1, 1'b1);
      vt[7]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, A+12,   1'b0, fmem(A+12),   1'b0, 1'b0, 1'b0);
      vt[8]  = mk(2'b10, A, 8'd4, B, 8'd1, 2'b10, 1'b0, A+12,   1'b0, fmem(A+12),   1'b0, 1'b0, 1'b1);
      vt[9]  = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b1, B,      1'b0, fmem(A+12),   1'b0, 1'b0, 1'b1);
      vt[10] = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, B,      1'b0, fmem(A+12),   1'b0, 1'b0, 1'b1);
      vt[11] = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, B,      1'b1, fmem(B),      1'b1, 1'b1, 1'b1);
      vt[12] = mk(2'b00, A, 8'd4, B, 8'd1, 2'b00, 1'b0, B,      1'b0, fmem(B),      1'b0, 1'b0, 1'b0);

      // Reset state, with requests pending to prove req_ready stays low.
      rst_n = 1'b0;
      req_valid = 2'b11;
      req_addr0 = 32'h10; req_addr1 = 32'h20; req_len0 = 8'd2; req_len1 = 8'd2;
      repeat (3) tick();
      check("ram_clk_hi", 128'(u1_rclk), 128'(1'b1));
      @(negedge clk);
      check("rst_u1", 128'(u1_outs()), 128'(0));
      check("rst_u3", 128'(u3_outs()), 128'(0));
      check("ram_consts", 128'({u1_rrst, u1_we, u1_wd, u3_rrst, u3_we, u3_wd}), 128'(0));
      tick();
      req_valid = 2'b00;
      rst_n = 1'b1;

      // Single burst then a one-word burst from requester 1, cycle by cycle.
      for (int i = 0; i < 13; i++) begin
         tick();
         req_valid = vt[i].vld;
         req_addr0 = vt[i].a0; req_len0 = vt[i].l0;
         req_addr1 = vt[i].a1; req_len1 = vt[i].l1;
         @(negedge clk);
         check($sformatf("vec%0d", i), 128'(u1_outs()), 128'(vt[i].exp));
      end

      // Simultaneous requests from reset: 0 first, then 1 at the next IDLE.
      do_reset();
      req_addr0 = 32'h1000; req_len0 = 8'd2; req_addr1 = 32'h2000; req_len1 = 8'd2;
      req_valid = 2'b11;
      b_g = g1_q.size(); b_a = a1_q.size(); g0 = cyc;
      repeat (12) begin
         @(negedge clk);
         acc = u1_rdy;
         tick();
         req_valid = req_valid & ~acc;
      end
      check("sim_ngrant", 128'(g1_q.size() - b_g), 128'(2));
      check("sim_naddr", 128'(a1_q.size() - b_a), 128'(4));
      if (g1_q.size() - b_g == 2 && a1_q.size() - b_a == 4) begin
         check("sim_g0", 128'({g1_q[b_g].cyc, g1_q[b_g].id}), 128'({g0, 1'b0}));
         check("sim_g1", 128'({g1_q[b_g+1].cyc, g1_q[b_g+1].id}), 128'({g0 + 3, 1'b1}));
         check("sim_addr", 128'({a1_q[b_a].v, a1_q[b_a+1].v, a1_q[b_a+2].v, a1_q[b_a+3].v}),
               {32'h1000, 32'h1004, 32'h2000, 32'h2004});
         check("sim_acyc", 128'({a1_q[b_a].cyc - g0, a1_q[b_a+1].cyc - g0,
                                 a1_q[b_a+2].cyc - g0, a1_q[b_a+3].cyc - g0}),
               {32'd1, 32'd2, 32'd4, 32'd5});
      end

      // Fairness: both held valid, one-word bursts alternate 0,1,0,1.
      do_reset();
      req_addr0 = 32'h300; req_len0 = 8'd1; req_addr1 = 32'h400; req_len1 = 8'd1;
      req_valid = 2'b11;
      b_g = g1_q.size(); g0 = cyc;
      repeat (8) tick();
      req_valid = 2'b00;
      check("fair_ngrant", 128'(g1_q.size() - b_g), 128'(4));
      if (g1_q.size() - b_g >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_g%0d", i), 128'({g1_q[b_g+i].cyc, g1_q[b_g+i].id}),
                  128'({g0 + 2 * i, 1'(i % 2)}));
         end
      end

      // Wrap and len=0 -> 256 words.
      repeat (4) tick();
      req_addr0 = 32'hFFFF_FFFC; req_len0 = 8'd0;
      req_valid = 2'b01;
      b_a = a1_q.size(); b_r = r1_q.size();
      @(negedge clk);
      check("wrap_grant", 128'(u1_rdy), 128'(2'b01));
      tick();
      req_valid = 2'b00;
      repeat (270) tick();
      check("wrap_naddr", 128'(a1_q.size() - b_a), 128'(256));
      check("wrap_nrd", 128'(r1_q.size() - b_r), 128'(256));
      if (a1_q.size() - b_a == 256 && r1_q.size() - b_r == 256) begin
         check("wrap_a1", 128'(a1_q[b_a+1].v), 128'(32'h0000_0000));
         check("wrap_alast", 128'(a1_q[b_a+255].v), 128'(32'h0000_03F8));
         bad = 0; nlast = 0;
         for (int i = 0; i < 256; i++) begin
            if (r1_q[b_r+i].v !== fmem(a1_q[b_a+i].v)) bad++;
            if (r1_q[b_r+i].last) nlast++;
         end
         check("wrap_data", 128'(bad), 128'(0));
         check("wrap_last", 128'({nlast, r1_q[b_r+255].last}), 128'({32'd1, 1'b1}));
      end

      // Reset mid-burst at the 3rd address cycle of a len=8 burst.
      do_reset();
      req_addr0 = 32'h800; req_len0 = 8'd8;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      check("mid_pre", 128'({u1_en, u1_addr}), 128'({1'b1, 32'h808}));
      rst_n = 1'b0;
      req_valid = 2'b11;
      @(negedge clk);
      check("mid_rst", 128'(u1_outs()), 128'(0));
      tick();
      rst_n = 1'b1;
      req_valid = 2'b00;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (u1_rv || u1_busy || u1_en || u3_rv || u3_busy) bad++;
         tick();
      end
      check("mid_quiet", 128'(bad), 128'(0));
      req_valid = 2'b11;
      @(negedge clk);
      check("mid_prio0", 128'(u1_rdy), 128'(2'b01));
      tick();
      req_valid = 2'b00;
      repeat (20) tick();

      // RD_LAT=3: data at k+4, id 1, order and contents preserved.
      do_reset();
      req_addr1 = 32'h80; req_len1 = 8'd3;
      req_valid = 2'b10;
      b_a = a3_q.size(); b_r = r3_q.size();
      tick();
      req_valid = 2'b00;
      repeat (12) tick();
      check("lat3_n", 128'({a3_q.size() - b_a, r3_q.size() - b_r}), 128'({32'd3, 32'd3}));
      if (a3_q.size() - b_a == 3 && r3_q.size() - b_r == 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("lat3_w%0d", i),
                  128'({a3_q[b_a+i].v, r3_q[b_r+i].cyc - a3_q[b_a+i].cyc, r3_q[b_r+i].v,
                        r3_q[b_r+i].id, r3_q[b_r+i].last}),
                  128'({32'h80 + 32'(4 * i), 32'd4, fmem(32'h80 + 32'(4 * i)), 1'b1, 1'(i == 2)}));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_rd_scheduler.md
BRAM_RD_SCHEDULER -- requirements
Module: bram_rd_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of BRAM byte address and request addresses.
REQ-002 SHALL have parameter DATA_W, default 32, width of BRAM read data.
REQ-003 SHALL have parameter LEN_W, default 8, width of burst length field; value 0 encodes 2^LEN_W words.
REQ-004 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles; legal range 1..3.
REQ-005 SHALL have clk input, 1 bit, clock; all logic on rising edge.
REQ-006 SHALL have rst_n input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have ram_clk output, 1 bit, tied to clk.
REQ-008 SHALL have ram_rst output, 1 bit, constant 0.
REQ-009 SHALL have ram_en output, 1 bit, registered BRAM enable, high only in address cycles.
REQ-010 SHALL have ram_addr output, ADDR_W bits, registered BRAM byte address.
REQ-011 SHALL have ram_we output, 4 bits, constant 0.
REQ-012 SHALL have ram_wd_data output, DATA_W bits, constant 0.
REQ-013 SHALL have ram_rd_data input, DATA_W bits, BRAM read data, valid RD_LAT cycles after its address cycle.
REQ-014 SHALL have req_valid[1:0] input, 2 bits, per-requester burst request; held until accepted.
REQ-015 SHALL have req_addr0 and req_addr1 inputs, ADDR_W bits each, burst start byte address, word aligned.
REQ-016 SHALL have req_len0 and req_len1 inputs, LEN_W bits each, burst length in words.
REQ-017 SHALL have req_ready[1:0] output, 2 bits, one-cycle accept pulse, at most one bit high.
REQ-018 SHALL have rd_valid output, 1 bit, registered read-data strobe; there is no backpressure.
REQ-019 SHALL have rd_data output, DATA_W bits, registered read word.
REQ-020 SHALL have rd_id output, 1 bit, requester index of the current rd_data word.
REQ-021 SHALL have rd_last output, 1 bit, high with the final word of a burst.
REQ-022 SHALL have busy output, 1 bit, high while in ISSUE state or while any read is in flight.

Function
REQ-023 SHALL implement a two-state FSM: IDLE and ISSUE.
REQ-024 SHALL, in IDLE with any req_valid high, grant one requester, pulse its req_ready that cycle, latch its addr/len, and enter ISSUE.
REQ-025 SHALL arbitrate round-robin: if both are valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-026 SHALL, in ISSUE, assert ram_en one cycle per word with ram_addr = start + 4*i, for i = 0..len-1, with no gaps; grant cycle N gives address cycles N+1..N+len.
REQ-027 SHALL wrap ram_addr modulo 2^ADDR_W, with no error indication.
REQ-028 SHALL return to IDLE in the cycle after the last address cycle; a new grant is allowed in that IDLE cycle, so the minimum gap between bursts is one cycle.
REQ-029 SHALL carry an {id, last} tag through a RD_LAT-deep shift pipeline alongside each address cycle.
REQ-030 SHALL register ram_rd_data into rd_data, so a word addressed in cycle k has rd_valid high in cycle k+RD_LAT+1, in issue order.
REQ-031 SHALL set rd_id and rd_last from the tag only when rd_valid is high; otherwise they are 0.
REQ-032 SHALL hold ram_addr, and leave rd_data unchanged, when ram_en or rd_valid respectively is low.
REQ-033 SHALL ignore req_valid changes while in ISSUE; requests are sampled only in IDLE.
REQ-034 SHALL keep busy high from the grant cycle until the cycle after the last rd_valid.

Reset
REQ-035 SHALL, on rst_n low, asynchronously clear FSM to IDLE, ram_en, ram_addr, req_ready, rd_valid, rd_data, rd_id, rd_last, busy, the tag pipeline and the round-robin pointer.
REQ-036 SHALL, on reset mid-burst, drop the remaining addresses and in-flight tags, with no rd_valid after reset deassertion until a new grant.

Verification
REQ-037 SHALL cover a single burst: req_valid=01, addr0=0x4580_0000, len0=4, RD_LAT=1 -> req_ready[0] in cycle N; addresses 0x4580_0000..0x4580_000C in N+1..N+4; rd_valid in N+3..N+6 with rd_last at N+6 and rd_id=0.
REQ-038 SHALL cover simultaneous requests: req_valid=11 from reset, len=2 each -> requester 0 granted first, requester 1 granted at the first IDLE, with no address gap beyond one cycle.
REQ-039 SHALL cover fairness: both requesters held valid continuously, len=1 -> grants alternate 0,1,0,1.
REQ-040 SHALL cover wrap and length encoding: addr=0xFFFF_FFFC, len=0 (256 words) -> 256 address cycles, the second address is 0x0000_0000, and exactly 256 rd_valid pulses occur.
REQ-041 SHALL cover reset mid-burst: rst_n low for 1 cycle at the 3rd address cycle of a len=8 burst -> all outputs 0, no rd_valid until a new grant, and requester 0 has priority again.
REQ-042 SHALL cover RD_LAT=3: a len=3 burst gives data at k+4 for each address cycle k, with matching ram_rd_data contents and order.
